cnl_job_sequencer: RTL and testbench

Host-side initiator for the cnn_layer_accel_quad job interface. It is the counterpart of the quad's job responder logic. It takes one job descriptor at a time from a command port and drives job_start/job_parameters. It answers each job_fetch_request with a job_fetch_ack plus a loader trigger, acknowledges job_complete, and reports per-job status on a completion port. It sits in the clk_if domain between the host command path and the quad.

---
 rtl/cnl_job_seq_pkg.sv | 26 ++
 rtl/cnl_watchdog_counter.sv | 32 +++
 rtl/cnl_job_sequencer.sv | 141 ++++++++++++++
 tb/tb_cnl_job_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnl_job_seq_pkg.sv
// Shared types and defaults for the cnl job sequencer: FSM states,
// completion status codes and default parameter widths.
package cnl_job_seq_pkg;

    localparam int DEF_PARAM_WIDTH     = 128;
    localparam int DEF_TAG_WIDTH       = 8;
    localparam int DEF_TIMEOUT_CYCLES  = 4096;
    localparam int DEF_FETCH_CNT_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        FACK,
        FETCH_WAIT,
        CACK,
        REPORT
    } seq_state_t;

    typedef logic [1:0] status_t;

    localparam status_t ST_OK        = 2'b00;
    localparam status_t ST_TIMEOUT   = 2'b01;
    localparam status_t ST_PROTO_ERR = 2'b10;

endpackage

// File: rtl/cnl_watchdog_counter.sv
// Watchdog: cleared by load, counts while enabled, flags expiry on the
// cycle the count reaches C_LIMIT-1. C_LIMIT of 0 never expires.
module cnl_watchdog_counter #(
    parameter int C_LIMIT = 4096
) (
    input  logic clk_if,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam int CW = (C_LIMIT > 1) ? $clog2(C_LIMIT) : 1;
    localparam logic [CW-1:0] LAST = (C_LIMIT > 0) ? CW'(C_LIMIT - 1) : '0;

    logic [CW-1:0] count;

    assign expire = (C_LIMIT != 0) && enable && (count == LAST);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk_if or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/cnl_job_sequencer.sv
// Host-side initiator for the quad job interface: issues one job at a time,
// services fetch rounds, acknowledges completion and reports status to the host.
module cnl_job_sequencer
    import cnl_job_seq_pkg::*;
#(
    parameter int C_PARAM_WIDTH     = DEF_PARAM_WIDTH,
    parameter int C_TAG_WIDTH       = DEF_TAG_WIDTH,
    parameter int C_TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter int C_FETCH_CNT_WIDTH = DEF_FETCH_CNT_WIDTH
) (
    input  logic                         clk_if,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [C_PARAM_WIDTH-1:0]     cmd_params,
    input  logic [C_TAG_WIDTH-1:0]       cmd_tag,
    output logic                         job_start,
    input  logic                         job_accept,
    output logic [C_PARAM_WIDTH-1:0]     job_parameters,
    input  logic                         job_fetch_request,
    output logic                         job_fetch_ack,
    input  logic                         job_fetch_complete,
    input  logic                         job_complete,
    output logic                         job_complete_ack,
    output logic                         fetch_go,
    output logic                         done_valid,
    input  logic                         done_ready,
    output logic [C_TAG_WIDTH-1:0]       done_tag,
    output logic [1:0]                   done_status,
    output logic [C_FETCH_CNT_WIDTH-1:0] fetch_count,
    output logic                         busy
);

    seq_state_t                   state, next_state;
    status_t                      status_q, status_next;
    logic [C_PARAM_WIDTH-1:0]     params_q;
    logic [C_TAG_WIDTH-1:0]       tag_q;
    logic [C_FETCH_CNT_WIDTH-1:0] fcnt_q;
    logic                         accept_cmd;
    logic                         wd_load, wd_enable, wd_expire;

    assign accept_cmd = (state == IDLE) && cmd_valid;
    assign wd_enable  = (state == START) || (state == FETCH_WAIT);
    assign wd_load    = (next_state != state) &&
                        ((next_state == START) || (next_state == FETCH_WAIT));

    cnl_watchdog_counter #(
        .C_LIMIT (C_TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_if (clk_if),
        .rst    (rst),
        .load   (wd_load),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    // NOTE: every variable written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        next_state  = state;
        status_next = status_q;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    next_state  = START;
                    status_next = ST_OK;
                end
            end
            START: begin
                if (job_accept) begin
                    next_state = RUN;
                end else if (wd_expire) begin
                    next_state  = REPORT;
                    status_next = ST_TIMEOUT;
                end
            end
            RUN: begin
                // Completion outranks a simultaneous fetch request, which is a protocol fault.
                if (job_complete) begin
                    next_state = CACK;
                    if (job_fetch_request) status_next = ST_PROTO_ERR;
                end else if (job_fetch_request) begin
                    next_state = FACK;
                end
            end
            FACK: next_state = FETCH_WAIT;
            FETCH_WAIT: begin
                if (job_complete) begin
                    next_state  = CACK;
                    status_next = ST_PROTO_ERR;
                end else if (job_fetch_complete) begin
                    next_state = RUN;
                end else if (wd_expire) begin
                    next_state  = REPORT;
                    status_next = ST_TIMEOUT;
                end
            end
            CACK: begin
                if (!job_complete) next_state = REPORT;
            end
            REPORT: begin
                if (done_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_if or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            status_q <= ST_OK;
            params_q <= '0;
            tag_q    <= '0;
            fcnt_q   <= '0;
        end else begin
            state    <= next_state;
            status_q <= status_next;
            if (accept_cmd) begin
                params_q <= cmd_params;
                tag_q    <= cmd_tag;
                fcnt_q   <= '0;
            end else if ((state == FACK) && !(&fcnt_q)) begin
                fcnt_q <= fcnt_q + C_FETCH_CNT_WIDTH'(1);
            end
        end
    end

    // All handshake outputs are decoded from state so reset clears them at once.
    assign cmd_ready        = (state == IDLE);
    assign busy             = (state != IDLE);
    assign job_start        = (state == START);
    assign job_fetch_ack    = (state == FACK);
    assign fetch_go         = (state == FACK);
    assign job_complete_ack = (state == CACK);
    assign done_valid       = (state == REPORT);
    assign job_parameters   = params_q;
    assign done_tag         = tag_q;
    assign done_status      = status_q;
    assign fetch_count      = fcnt_q;

endmodule

// File: tb/tb_cnl_job_sequencer.sv
// Directed bench for cnl_job_sequencer: basic job, timeout, protocol error,
// completion back-pressure, mid-job reset and back-to-back commands.
module tb_cnl_job_sequencer;

    localparam int PW = 128;
    localparam int TW = 8;
    localparam int FW = 16;

    logic          clk_if = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready;
    logic [PW-1:0] cmd_params;
    logic [TW-1:0] cmd_tag;
    logic          job_start, job_accept;
    logic [PW-1:0] job_parameters;
    logic          job_fetch_request, job_fetch_ack, job_fetch_complete;
    logic          job_complete, job_complete_ack, fetch_go;
    logic          done_valid, done_ready;
    logic [TW-1:0] done_tag;
    logic [1:0]    done_status;
    logic [FW-1:0] fetch_count;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;
    int ack_cnt = 0;
    int go_cnt = 0;

    cnl_job_sequencer #(
        .C_PARAM_WIDTH     (PW),
        .C_TAG_WIDTH       (TW),
        .C_TIMEOUT_CYCLES  (16),
        .C_FETCH_CNT_WIDTH (FW)
    ) dut (
        .clk_if             (clk_if),
        .rst                (rst),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_params         (cmd_params),
        .cmd_tag            (cmd_tag),
        .job_start          (job_start),
        .job_accept         (job_accept),
        .job_parameters     (job_parameters),
        .job_fetch_request  (job_fetch_request),
        .job_fetch_ack      (job_fetch_ack),
        .job_fetch_complete (job_fetch_complete),
        .job_complete       (job_complete),
        .job_complete_ack   (job_complete_ack),
        .fetch_go           (fetch_go),
        .done_valid         (done_valid),
        .done_ready         (done_ready),
        .done_tag           (done_tag),
        .done_status        (done_status),
        .fetch_count        (fetch_count),
        .busy               (busy)
    );

    always #5 clk_if = ~clk_if;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk_if) begin
        if (rst && job_fetch_ack) ack_cnt++;
        if (rst && fetch_go) go_cnt++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_if);
        #1;
    endtask

    task automatic send_cmd(input logic [TW-1:0] tag, input logic [PW-1:0] params);
        cmd_valid  = 1'b1;
        cmd_tag    = tag;
        cmd_params = params;
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic accept_job();
        job_accept = 1'b1;
        tick();
        job_accept = 1'b0;
    endtask

    task automatic fetch_round();
        job_fetch_request = 1'b1;
        tick();
        job_fetch_request = 1'b0;
        tick();
        job_fetch_complete = 1'b1;
        tick();
        job_fetch_complete = 1'b0;
    endtask

    task automatic finish_job();
        job_complete = 1'b1;
        tick();
        tick();
        job_complete = 1'b0;
        tick();
    endtask

    task automatic take_done();
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
    endtask

    localparam logic [PW-1:0] P1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [PW-1:0] P2 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    localparam logic [PW-1:0] PA = 128'hAAAA_0000_AAAA_0000_AAAA_0000_AAAA_0001;
    localparam logic [PW-1:0] PB = 128'hBBBB_1111_BBBB_1111_BBBB_1111_BBBB_2222;

    initial begin
        int n;
        rst = 1'b0;
        cmd_valid = 1'b0; cmd_params = '0; cmd_tag = '0;
        job_accept = 1'b0; job_fetch_request = 1'b0; job_fetch_complete = 1'b0;
        job_complete = 1'b0; done_ready = 1'b0;
        tick();
        tick();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_job_start", job_start, 0);
        check("rst_busy", busy, 0);
        check("rst_done_valid", done_valid, 0);
        check("rst_params", job_parameters, 0);
        check("rst_fetch_count", fetch_count, 0);
        rst = 1'b1;
        tick();

        // Basic job: accept 3 cycles after job_start, two fetch rounds, completion.
        ack_cnt = 0; go_cnt = 0;
        send_cmd(8'h2A, P1);
        check("b_job_start", job_start, 1);
        check("b_cmd_ready", cmd_ready, 0);
        check("b_params", job_parameters, P1);
        tick();
        tick();
        check("b_start_held", job_start, 1);
        accept_job();
        check("b_start_drop", job_start, 0);
        job_fetch_request = 1'b1;
        tick();
        job_fetch_request = 1'b0;
        check("b_fack", job_fetch_ack, 1);
        check("b_fetch_go", fetch_go, 1);
        tick();
        check("b_fack_pulse", job_fetch_ack, 0);
        job_fetch_complete = 1'b1;
        tick();
        job_fetch_complete = 1'b0;
        fetch_round();
        job_complete = 1'b1;
        tick();
        check("b_cack_rise", job_complete_ack, 1);
        tick();
        check("b_cack_hold", job_complete_ack, 1);
        job_complete = 1'b0;
        tick();
        check("b_cack_drop", job_complete_ack, 0);
        check("b_ack_pulses", ack_cnt, 2);
        check("b_go_pulses", go_cnt, 2);
        // Host back-pressure: record must stay put while done_ready is low.
        for (int i = 0; i < 10; i++) begin
            check("b_dv_hold", done_valid, 1);
            check("b_tag_hold", done_tag, 8'h2A);
            check("b_status_hold", done_status, 2'b00);
            check("b_fcnt_hold", fetch_count, 2);
            check("b_cmd_ready_low", cmd_ready, 0);
            tick();
        end
        take_done();
        check("b_cmd_ready_back", cmd_ready, 1);
        check("b_dv_drop", done_valid, 0);

        // Timeout: job_accept withheld, job_start lasts exactly 16 cycles.
        send_cmd(8'h11, P2);
        n = 0;
        for (int i = 0; i < 40 && job_start; i++) begin
            n++;
            tick();
        end
        check("t_start_cycles", n, 16);
        check("t_done_valid", done_valid, 1);
        check("t_status", done_status, 2'b01);
        check("t_fetch_count", fetch_count, 0);
        check("t_tag", done_tag, 8'h11);
        take_done();

        // Fetch request coinciding with completion in RUN: protocol error, no ack.
        ack_cnt = 0; go_cnt = 0;
        send_cmd(8'h33, P1);
        accept_job();
        job_fetch_request = 1'b1;
        job_complete = 1'b1;
        tick();
        check("p_no_fack", job_fetch_ack, 0);
        check("p_cack", job_complete_ack, 1);
        job_fetch_request = 1'b0;
        job_complete = 1'b0;
        tick();
        check("p_done_valid", done_valid, 1);
        check("p_status", done_status, 2'b10);
        check("p_ack_pulses", ack_cnt, 0);
        check("p_go_pulses", go_cnt, 0);
        take_done();

        // Reset during FETCH_WAIT: outputs clear asynchronously, no completion record.
        send_cmd(8'h44, P2);
        accept_job();
        job_fetch_request = 1'b1;
        tick();
        job_fetch_request = 1'b0;
        tick();
        check("r_busy_pre", busy, 1);
        rst = 1'b0;
        #1;
        check("r_cmd_ready", cmd_ready, 1);
        check("r_busy", busy, 0);
        check("r_job_start", job_start, 0);
        check("r_fack", job_fetch_ack, 0);
        check("r_done_valid", done_valid, 0);
        check("r_params", job_parameters, 0);
        check("r_fcnt", fetch_count, 0);
        tick();
        rst = 1'b1;
        tick();
        check("r_no_done", done_valid, 0);
        send_cmd(8'h77, P1);
        check("r2_params", job_parameters, P1);
        accept_job();
        fetch_round();
        finish_job();
        check("r2_done_valid", done_valid, 1);
        check("r2_tag", done_tag, 8'h77);
        check("r2_status", done_status, 2'b00);
        check("r2_fcnt", fetch_count, 1);
        take_done();

        // Back-to-back commands with cmd_valid held high.
        cmd_valid  = 1'b1;
        cmd_tag    = 8'h51;
        cmd_params = PA;
        tick();
        cmd_tag    = 8'h52;
        cmd_params = PB;
        check("bb_a_params", job_parameters, PA);
        accept_job();
        finish_job();
        check("bb_a_done", done_valid, 1);
        check("bb_a_tag", done_tag, 8'h51);
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        check("bb_idle_gap", job_start, 0);
        check("bb_idle_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("bb_b_start", job_start, 1);
        check("bb_b_params", job_parameters, PB);
        accept_job();
        finish_job();
        check("bb_b_tag", done_tag, 8'h52);
        check("bb_b_status", done_status, 2'b00);
        take_done();
        check("bb_end_ready", cmd_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
